// File: rtl/rs_pkg.sv
// Shared RS(204,188) constants, GF(2^8) helpers and FSM state type.
// Used by both the encoder and the decoder.
package rs_pkg;

  localparam int RS_N = 204;
  localparam int RS_K = 188;
  localparam int NPAR = 16;
  localparam logic [8:0] PRIM = 9'h11D;

  typedef enum logic {
    DATA,
    PARITY
  } rs_state_e;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      if (x[7]) x = (x << 1) ^ PRIM[7:0];
      else      x = x << 1;
    end
    return p;
  endfunction

  // g(x) = prod (x + alpha^i), i = 0..15; entry j is the x^j coefficient.
  function automatic logic [NPAR-1:0][7:0] gen_poly();
    logic [NPAR:0][7:0] g;
    logic [7:0] root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--)
        g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g[NPAR-1:0];
  endfunction

  localparam logic [NPAR-1:0][7:0] GEN = gen_poly();

endpackage

// File: rtl/rs_gf_mul_const.sv
// GF(2^8) multiply by a fixed coefficient; folds to an XOR network.
module rs_gf_mul_const
  import rs_pkg::*;
#(
  parameter logic [7:0] C = 8'h01
) (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = gf_mul(a_i, C);

endmodule

// File: rtl/rs_enc.sv
// Systematic RS(N,K) encoder: data passes through, then 16 parity bytes
// drained from a generator-polynomial LFSR.
module rs_enc
  import rs_pkg::*;
#(
  parameter int N = RS_N,
  parameter int K = RS_K
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic [7:0] input_byte,
  output logic       in_ready,
  output logic [7:0] Out_byte,
  output logic       CEO,
  output logic       Valid_out
);

  localparam int CW = $clog2(N + 1);

  rs_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NPAR-1:0][7:0] lfsr_q, lfsr_d;
  logic [NPAR-1:0][7:0] prod;
  logic [7:0] out_q, out_d;
  logic [7:0] fb;
  logic ceo_q;
  logic valid_q, valid_d;

  assign fb = input_byte ^ lfsr_q[NPAR-1];

  for (genvar j = 0; j < NPAR; j++) begin : g_mul
    rs_gf_mul_const #(
      .C (GEN[j])
    ) u_mul (
      .a_i (fb),
      .y_o (prod[j])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    valid_d = valid_q;
    if (CE) begin
      valid_d = 1'b1;
      unique case (state_q)
        DATA: begin
          out_d  = input_byte;
          lfsr_d = {lfsr_q[NPAR-2:0], 8'h00} ^ prod;
          if (cnt_q == CW'(K - 1)) begin
            state_d = PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PARITY: begin
          out_d  = lfsr_q[NPAR-1];
          lfsr_d = {lfsr_q[NPAR-2:0], 8'h00};
          if (cnt_q == CW'(NPAR - 1)) begin
            state_d = DATA;
            cnt_d   = '0;
            lfsr_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end else if (state_q == DATA && cnt_q == '0) begin
      // Idle between codewords: drop Valid after the last parity byte.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DATA;
      cnt_q   <= '0;
      lfsr_q  <= '0;
      out_q   <= '0;
      ceo_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      ceo_q   <= CE;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == DATA);
  assign Out_byte  = out_q;
  assign CEO       = ceo_q;
  assign Valid_out = valid_q;

endmodule

// File: doc/rs_enc.md
RS_ENC -- requirements
Module: rs_enc

Interface
REQ-001 The module SHALL have parameter N, default 204, meaning codeword length in bytes.
REQ-002 The module SHALL have parameter K, default 188, meaning data bytes per block; N-K = 16 parity bytes.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port CE, input, 1 bit: byte strobe, high for one clk per byte slot.
REQ-006 The module SHALL have port input_byte, input, 8 bits: data byte, sampled when CE && in_ready.
REQ-007 The module SHALL have port in_ready, output, 1 bit: high while data bytes are accepted, low during parity emission.
REQ-008 The module SHALL have port Out_byte, output, 8 bits: codeword byte, systematic order (data first, then parity).
REQ-009 The module SHALL have port CEO, output, 1 bit: high for one clk with each new Out_byte.
REQ-010 The module SHALL have port Valid_out, output, 1 bit: high from the first through the N-th byte of each codeword.

Function
REQ-011 Arithmetic SHALL be in GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
REQ-012 The generator SHALL be g(x) = prod(i=0..15)(x + alpha^i); code is RS(255,239) shortened to (N,K) by implicit leading zeros.
REQ-013 Encoding SHALL use a 16-stage LFSR: feedback = input_byte XOR stage[15]; stage[j] <= stage[j-1] XOR gf_mul(feedback, g_j), stage[0] <= gf_mul(feedback, g_0).
REQ-014 The FSM SHALL have states DATA and PARITY; reset state SHALL be DATA with byte counter = 0.
REQ-015 In DATA, each CE SHALL register Out_byte = input_byte, advance the LFSR and increment the counter.
REQ-016 On the CE that accepts byte K-1, the FSM SHALL go to PARITY and clear the counter; in_ready SHALL be low from the next clk.
REQ-017 In PARITY, each CE SHALL emit Out_byte = stage[15] then shift the stages up by one with zero fill; input_byte SHALL be ignored.
REQ-018 On the 16th parity CE the FSM SHALL return to DATA with counter 0 and LFSR all-zero; in_ready SHALL be high from the next clk.
REQ-019 Latency: Out_byte and CEO SHALL update on the rising edge at which CE is sampled high (one-clk registered delay from the strobe).
REQ-020 CE low SHALL hold all state; CE on consecutive clks SHALL be legal, one byte per clk.
REQ-021 Valid_out SHALL rise with CEO of byte 0, fall after CEO of byte N-1, and stay high across CE gaps within a codeword.
REQ-022 Blocks SHALL be back-to-back with no idle slot required between the last parity byte and the next data byte.

Reset
REQ-023 Asserting reset (low) at any time, including mid-block, SHALL immediately force Out_byte=0, CEO=0, Valid_out=0, in_ready=1, LFSR=0, counter=0, state=DATA.
REQ-024 After deassertion, the first accepted byte SHALL be byte 0 of a new block; no partial codeword SHALL be emitted.

Structure
REQ-025 A shared package rs_pkg SHALL hold N, K, NPAR=16, the primitive polynomial, the 16 generator coefficients g_0..g_15, and the FSM state type; the decoder SHALL reuse the same package.
REQ-026 A single sub-module rs_gf_mul_const (8-bit GF multiply by a constant coefficient, combinational) SHALL be instantiated 16 times.

Verification
REQ-027 All-zero block (188 x 0x00) -> 204 x 0x00 output, Valid_out high for exactly 204 CEOs.
REQ-028 Data 0x00 x187 then 0x01 -> 16 parity bytes equal g_15..g_0 (the generator coefficients, highest first).
REQ-029 100 random blocks with a CE pattern of 1 high + 7 low, output fed to RS_dec (reset at 0 deasserted) -> byte-exact match with golden file and "No Errors".
REQ-030 During PARITY, toggle input_byte to 0xFF on every CE -> parity unchanged, in_ready low for exactly 16 CEs.
REQ-031 Reset pulse after data byte 100 -> outputs 0 within the same cycle; the next block encodes identically to a fresh run.
REQ-032 CE held high continuously for 2 blocks -> 408 consecutive CEOs, Valid_out high throughout, both codewords correct.
